// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive path.
package usb_rx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      DATA,
      EOP_CHK,
      ERROR
   } rxState_e;

   typedef enum logic [1:0] {
      LINE_J,
      LINE_K,
      LINE_SE0
   } lineState_e;

   localparam logic [7:0] SYNC_BYTE   = 8'h80;
   localparam int         STUFF_LIMIT = 6;

   // Both lines high is not a legal driven state; it is folded into SE0.
   function automatic lineState_e decodeLine(input logic dPlus, input logic dMinus);
      lineState_e line;
      if (dPlus && !dMinus) begin
         line = LINE_J;
      end else if (!dPlus && dMinus) begin
         line = LINE_K;
      end else begin
         line = LINE_SE0;
      end
      return line;
   endfunction

endpackage

// File: rtl/rx_bit_sampler.sv
// Bit recovery front end: optional input synchronizer (RX_INPUT_SYNC_EN),
// edge-resynchronised sample counter, sample strobe and NRZI decoding.
module rx_bit_sampler
   import usb_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 8,
   parameter int SAMPLE_POINT = 3
) (
   input  logic clk,
   input  logic n_rst,
   input  logic dPlus_i,
   input  logic dMinus_i,
   output logic sample_o,
   output logic bit_o,
   output logic se0_o,
   output logic lineJ_o,
   output logic kEdge_o
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_MAX    = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_SAMPLE = CW'(SAMPLE_POINT);

   logic dPlus;
   logic dMinus;

`ifdef RX_INPUT_SYNC_EN
   logic [1:0] dPlusSync_q;
   logic [1:0] dMinusSync_q;

   // Two-flop synchronizers on each pin; they reset to the idle J level.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         dPlusSync_q  <= 2'b11;
         dMinusSync_q <= 2'b00;
      end else begin
         dPlusSync_q  <= {dPlusSync_q[0], dPlus_i};
         dMinusSync_q <= {dMinusSync_q[0], dMinus_i};
      end
   end

   assign dPlus  = dPlusSync_q[1];
   assign dMinus = dMinusSync_q[1];
`else
   assign dPlus  = dPlus_i;
   assign dMinus = dMinus_i;
`endif

   lineState_e      lineNow;
   lineState_e      lineLast_q;
   lineState_e      lineLast_d;
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   cnt_d;
   logic            level_q;
   logic            level_d;
   logic            jkEdge;

   assign lineNow  = decodeLine(dPlus, dMinus);
   assign jkEdge   = ((lineNow == LINE_J) && (lineLast_q == LINE_K)) ||
                     ((lineNow == LINE_K) && (lineLast_q == LINE_J));
   assign kEdge_o  = (lineNow == LINE_K) && (lineLast_q == LINE_J);
   assign se0_o    = (lineNow == LINE_SE0);
   assign lineJ_o  = (lineNow == LINE_J);
   // No sample on an edge cycle, so the level just entered is never mistaken for the old bit.
   assign sample_o = (cnt_q == CNT_SAMPLE) && !jkEdge;
   assign bit_o    = ~(lineJ_o ^ level_q);

   // Counter restarts on every J/K edge to track transmitter drift; level remembers the last J/K sample.
   always_comb begin
      lineLast_d = lineNow;
      cnt_d      = cnt_q;
      level_d    = level_q;
      if (jkEdge || (cnt_q == CNT_MAX)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
      if (sample_o && !se0_o) begin
         level_d = lineJ_o;
      end
   end

   // Sampler state register; previous level starts at J.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         lineLast_q <= LINE_J;
         cnt_q      <= '0;
         level_q    <= 1'b1;
      end else begin
         lineLast_q <= lineLast_d;
         cnt_q      <= cnt_d;
         level_q    <= level_d;
      end
   end

endmodule

// File: rtl/byte_receiver.sv
// USB full-speed receive byte engine: unstuffing, SYNC check, LSB-first byte
// assembly and EOP detection. RX_INPUT_SYNC_EN adds a pin synchronizer.
module byte_receiver
   import usb_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 8,
   parameter int SAMPLE_POINT = 3
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       d_plus,
   input  logic       d_minus,
   output logic [7:0] rcv_byte,
   output logic       byte_ready,
   output logic       rcving,
   output logic       rcv_error,
   output logic       eop
);

   logic sampleStb;
   logic rxBit;
   logic se0;
   logic lineJ;
   logic kEdge;

   rx_bit_sampler #(
      .CLKS_PER_BIT(CLKS_PER_BIT),
      .SAMPLE_POINT(SAMPLE_POINT)
   ) u_sampler (
      .clk      (clk),
      .n_rst    (n_rst),
      .dPlus_i  (d_plus),
      .dMinus_i (d_minus),
      .sample_o (sampleStb),
      .bit_o    (rxBit),
      .se0_o    (se0),
      .lineJ_o  (lineJ),
      .kEdge_o  (kEdge)
   );

   rxState_e   state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bitCnt_q, bitCnt_d;
   logic [2:0] ones_q, ones_d;
   logic       se0Seen_q, se0Seen_d;
   logic [7:0] rcvByte_q, rcvByte_d;
   logic       byteReady_q, byteReady_d;
   logic       rcving_q, rcving_d;
   logic       rcvError_q, rcvError_d;
   logic       eop_q, eop_d;
   logic [7:0] newByte;
   logic       stuffPending;

   assign newByte      = {rxBit, shift_q[7:1]};
   assign stuffPending = (ones_q == 3'(STUFF_LIMIT));

   // Packet FSM: unstuffs bits, checks SYNC, assembles bytes and validates EOP.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bitCnt_d    = bitCnt_q;
      ones_d      = ones_q;
      se0Seen_d   = se0Seen_q;
      rcvByte_d   = rcvByte_q;
      byteReady_d = 1'b0;
      rcving_d    = rcving_q;
      rcvError_d  = rcvError_q;
      eop_d       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (kEdge) begin
               state_d    = SYNC;
               rcving_d   = 1'b1;
               rcvError_d = 1'b0;
               bitCnt_d   = '0;
               ones_d     = '0;
               se0Seen_d  = 1'b0;
            end
         end
         SYNC, DATA: begin
            if (sampleStb && se0) begin
               if (state_q == SYNC) begin
                  rcvError_d = 1'b1;
                  state_d    = ERROR;
                  se0Seen_d  = 1'b1;
               end else begin
                  state_d   = EOP_CHK;
                  se0Seen_d = 1'b0;
                  if (bitCnt_q != 3'd0) begin
                     rcvError_d = 1'b1;
                  end
               end
            end else if (sampleStb) begin
               if (stuffPending) begin
                  ones_d = '0;
                  if (rxBit) begin
                     rcvError_d = 1'b1;
                     state_d    = ERROR;
                     se0Seen_d  = 1'b0;
                  end
               end else begin
                  ones_d   = rxBit ? (ones_q + 3'd1) : 3'd0;
                  shift_d  = newByte;
                  bitCnt_d = bitCnt_q + 3'd1;
                  if (bitCnt_q == 3'd7) begin
                     if (state_q == SYNC) begin
                        if (newByte == SYNC_BYTE) begin
                           state_d = DATA;
                        end else begin
                           rcvError_d = 1'b1;
                           state_d    = ERROR;
                           se0Seen_d  = 1'b0;
                        end
                     end else begin
                        rcvByte_d   = newByte;
                        byteReady_d = 1'b1;
                     end
                  end
               end
            end
         end
         EOP_CHK: begin
            if (sampleStb) begin
               if (!se0Seen_q) begin
                  if (se0) begin
                     se0Seen_d = 1'b1;
                  end else begin
                     rcvError_d = 1'b1;
                     state_d    = ERROR;
                  end
               end else if (lineJ) begin
                  eop_d    = 1'b1;
                  rcving_d = 1'b0;
                  state_d  = IDLE;
               end else if (!se0) begin
                  rcvError_d = 1'b1;
                  state_d    = ERROR;
                  se0Seen_d  = 1'b0;
               end
            end
         end
         ERROR: begin
            if (sampleStb) begin
               if (se0) begin
                  se0Seen_d = 1'b1;
               end else if (se0Seen_q && lineJ) begin
                  rcving_d = 1'b0;
                  state_d  = IDLE;
               end else begin
                  se0Seen_d = 1'b0;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Receiver state and output registers.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         bitCnt_q    <= '0;
         ones_q      <= '0;
         se0Seen_q   <= 1'b0;
         rcvByte_q   <= '0;
         byteReady_q <= 1'b0;
         rcving_q    <= 1'b0;
         rcvError_q  <= 1'b0;
         eop_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bitCnt_q    <= bitCnt_d;
         ones_q      <= ones_d;
         se0Seen_q   <= se0Seen_d;
         rcvByte_q   <= rcvByte_d;
         byteReady_q <= byteReady_d;
         rcving_q    <= rcving_d;
         rcvError_q  <= rcvError_d;
         eop_q       <= eop_d;
      end
   end

   assign rcv_byte   = rcvByte_q;
   assign byte_ready = byteReady_q;
   assign rcving     = rcving_q;
   assign rcv_error  = rcvError_q;
   assign eop        = eop_q;

endmodule

// File: tb/tb_byte_receiver.sv
// Testbench for byte_receiver: builds USB bit streams from byte lists
// (serialise, stuff, NRZI, EOP) and compares what the receiver reports.
`timescale 1ns/1ps
module tb_byte_receiver;

`ifdef RX_INPUT_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif
   localparam int LVL_J   = 0;
   localparam int LVL_K   = 1;
   localparam int LVL_SE0 = 2;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       d_plus = 1'b1;
   logic       d_minus = 1'b0;
   logic [7:0] rcv_byte;
   logic       byte_ready;
   logic       rcving;
   logic       rcv_error;
   logic       eop;

   byte_receiver dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .d_plus     (d_plus),
      .d_minus    (d_minus),
      .rcv_byte   (rcv_byte),
      .byte_ready (byte_ready),
      .rcving     (rcving),
      .rcv_error  (rcv_error),
      .eop        (eop)
   );

   // 96 MHz is only nominal here; the bench works in clock cycles.
   always #5 clk = ~clk;

   int cyc = 0;

   // Free-running posedge count used to time latencies.
   always @(posedge clk) cyc <= cyc + 1;

   int         passCount = 0;
   int         checkCount = 0;
   int         failCount = 0;
   logic [7:0] gotBytes[$];
   int         eopCount = 0;
   int         riseCycle = -1;
   logic       rcvingLast = 1'b0;

   // Monitor: records every byte_ready cycle, eop cycle and rcving rising edge.
   always @(negedge clk) begin
      if (byte_ready) gotBytes.push_back(rcv_byte);
      if (eop) eopCount = eopCount + 1;
      if (rcving && !rcvingLast) riseCycle = cyc;
      rcvingLast = rcving;
   end

   int         levels[$];
   logic [7:0] payload[$];
   logic [7:0] expBytes[$];
   int         kCycle = 0;
   int         byteBase = 0;
   int         eopBase = 0;

   task automatic driveLevel(input int lvl);
      case (lvl)
         LVL_J:   begin d_plus = 1'b1; d_minus = 1'b0; end
         LVL_K:   begin d_plus = 1'b0; d_minus = 1'b1; end
         default: begin d_plus = 1'b0; d_minus = 1'b0; end
      endcase
   endtask

   // Reference encoder: SYNC and payload LSB-first, a 0 after every six 1s, NRZI from J, then EOP.
   task automatic buildPacket(input logic [7:0] syncByte, input int extraBits,
                              input logic [7:0] extraVal, input bit stuffEn, input bit withEop);
      bit bits[$];
      bit stuffed[$];
      int run;
      int lvl;
      levels.delete();
      repeat (2) levels.push_back(LVL_J);
      for (int i = 0; i < 8; i++) bits.push_back(syncByte[i]);
      foreach (payload[b]) begin
         for (int i = 0; i < 8; i++) bits.push_back(payload[b][i]);
      end
      for (int i = 0; i < extraBits; i++) bits.push_back(extraVal[i]);
      run = 0;
      foreach (bits[i]) begin
         stuffed.push_back(bits[i]);
         run = bits[i] ? run + 1 : 0;
         if (stuffEn && run == 6) begin
            stuffed.push_back(1'b0);
            run = 0;
         end
      end
      lvl = LVL_J;
      foreach (stuffed[i]) begin
         if (!stuffed[i]) lvl = (lvl == LVL_J) ? LVL_K : LVL_J;
         levels.push_back(lvl);
      end
      if (withEop) begin
         levels.push_back(LVL_SE0);
         levels.push_back(LVL_SE0);
         repeat (4) levels.push_back(LVL_J);
      end
   endtask

   task automatic buildEop();
      levels.delete();
      levels.push_back(LVL_SE0);
      levels.push_back(LVL_SE0);
      repeat (4) levels.push_back(LVL_J);
   endtask

   // Plays the level list with a bit period of period/100 clocks, optionally cut short.
   task automatic applyStimulus(input int period, input int maxCycles);
      int total;
      int idx;
      bit sawK;
      sawK = 1'b0;
      total = (levels.size() * period + 99) / 100;
      if (maxCycles > 0 && maxCycles < total) total = maxCycles;
      for (int c = 0; c < total; c++) begin
         idx = (c * 100) / period;
         driveLevel(levels[idx]);
         if (!sawK && levels[idx] == LVL_K) begin
            sawK = 1'b1;
            kCycle = cyc;
         end
         @(negedge clk);
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic startPacket();
      byteBase = gotBytes.size();
      eopBase  = eopCount;
   endtask

   task automatic checkPacket(input string tag, input logic expErr, input int expEop);
      int got;
      got = gotBytes.size() - byteBase;
      checkOutput({tag, "_byte_count"}, got, expBytes.size());
      for (int i = 0; i < expBytes.size() && i < got; i++) begin
         checkOutput($sformatf("%s_byte%0d", tag, i), gotBytes[byteBase + i], expBytes[i]);
      end
      checkOutput({tag, "_eop_count"}, eopCount - eopBase, expEop);
      checkOutput({tag, "_rcv_error"}, rcv_error, expErr);
      checkOutput({tag, "_rcving_idle"}, rcving, 0);
   endtask

   task automatic cleanPacket(input string tag, input int period);
      buildPacket(8'h80, 0, 8'h00, 1'b1, 1'b1);
      startPacket();
      applyStimulus(period, 0);
      expBytes = payload;
      checkPacket(tag, 1'b0, 1);
   endtask

   initial begin
      $display("[TB] byte_receiver bench start");
      driveLevel(LVL_J);
      n_rst = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_rcv_byte", rcv_byte, 0);
      checkOutput("reset_byte_ready", byte_ready, 0);
      checkOutput("reset_rcving", rcving, 0);
      checkOutput("reset_rcv_error", rcv_error, 0);
      checkOutput("reset_eop", eop, 0);
      n_rst = 1'b1;
      repeat (16) @(negedge clk);

      // Single byte A5 with rcving latency
      payload = '{8'hA5};
      cleanPacket("a5", 800);
      checkOutput("a5_rcving_latency", riseCycle, kCycle + 1 + SYNC_LAT);

      // FF then 00: stuffed zero must vanish
      payload = '{8'hFF, 8'h00};
      cleanPacket("ff00", 800);

      // Unstuffed run of ones: stuff error, hold rcving until SE0/J
      payload = '{8'hFF};
      buildPacket(8'h80, 0, 8'h00, 1'b0, 1'b0);
      startPacket();
      applyStimulus(800, 0);
      checkOutput("ones_err_rcving_hold", rcving, 1);
      checkOutput("ones_err_flag_early", rcv_error, 1);
      buildEop();
      applyStimulus(800, 0);
      expBytes.delete();
      checkPacket("ones_err", 1'b1, 0);

      // Bad SYNC 81, then a clean packet clears the error
      payload = '{8'h5A};
      buildPacket(8'h81, 0, 8'h00, 1'b1, 1'b1);
      startPacket();
      applyStimulus(800, 0);
      expBytes.delete();
      checkPacket("bad_sync", 1'b1, 0);
      payload = '{8'($urandom)};
      cleanPacket("after_bad_sync", 800);

      // 3C followed by a partial nibble
      payload = '{8'h3C};
      buildPacket(8'h80, 4, 8'($urandom_range(0, 15)), 1'b1, 1'b1);
      startPacket();
      applyStimulus(800, 0);
      expBytes = payload;
      checkPacket("partial", 1'b1, 1);

      // Clock drift at both ends of the tolerance
      payload = '{8'hC3};
      cleanPacket("drift_fast", 772);
      payload = '{8'hC3};
      cleanPacket("drift_slow", 828);

      // Random multi-byte packets with small random drift
      for (int p = 0; p < 6; p++) begin
         int n;
         n = int'($urandom_range(1, 4));
         payload.delete();
         for (int b = 0; b < n; b++) payload.push_back(8'($urandom));
         cleanPacket($sformatf("rand%0d", p), int'($urandom_range(790, 810)));
      end

      // Reset in the middle of a data byte
      payload = '{8'hC3, 8'h5A};
      buildPacket(8'h80, 0, 8'h00, 1'b1, 1'b1);
      applyStimulus(800, 14 * 8);
      checkOutput("midrst_rcving_before", rcving, 1);
      n_rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_rcv_byte", rcv_byte, 0);
      checkOutput("midrst_byte_ready", byte_ready, 0);
      checkOutput("midrst_rcving", rcving, 0);
      checkOutput("midrst_rcv_error", rcv_error, 0);
      checkOutput("midrst_eop", eop, 0);
      driveLevel(LVL_J);
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      repeat (16) @(negedge clk);
      payload = '{8'h96};
      cleanPacket("after_reset", 800);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/byte_receiver.md
# byte_receiver

USB full-speed receive-side byte engine: recovers bits from the oversampled d_plus/d_minus pair, NRZI-decodes, removes stuffed bits, checks SYNC, assembles LSB-first bytes and detects EOP. It sits between the bus pins and the receive FIFO/packet FSM and is the counterpart of byte_transmitter. It runs at 96 MHz, 8 clocks per 12 Mbps bit.

## Interface
- CLKS_PER_BIT, 8, clocks per bus bit; counter width is $clog2(CLKS_PER_BIT).
- SAMPLE_POINT, 3, counter value at which the line is sampled; range 1..CLKS_PER_BIT-2.
- clk  in  1  system clock, 96 MHz.
- n_rst  in  1  reset; synchronous, active-low, sampled on rising clk.
- d_plus  in  1  bus D+.
- d_minus  in  1  bus D-.
- rcv_byte  out  8  last assembled byte, LSB = first bit received; holds until the next byte completes.
- byte_ready  out  1  one-cycle pulse when rcv_byte is updated. No back-pressure; the consumer must take it that cycle.
- rcving  out  1  high from SYNC start to EOP or error recovery.
- rcv_error  out  1  sticky error flag; cleared at the next packet start.
- eop  out  1  one-cycle pulse on a valid EOP.

## Operation
- Line states:
  - J = (1,0); K = (0,1); SE0 = (0,0); (1,1) is treated as SE0.
  - Idle is J.
- Bit timing:
  - The sample counter resets to 0 on any J↔K transition and otherwise counts, wrapping at CLKS_PER_BIT-1.
  - The line is sampled when counter == SAMPLE_POINT.
- NRZI decoding: decoded bit = 1 if the sampled level equals the previous sampled level, 0 otherwise. The previous level resets to J.
- Unstuffing:
  - A ones-counter increments on each decoded 1 and clears on each 0.
  - After six consecutive 1s, the next bit is dropped and the counter clears.
  - If that dropped bit is 1, set rcv_error and go to ERROR.
- FSM states: IDLE, SYNC, DATA, EOP_CHK, ERROR.
  - IDLE → SYNC on the first J→K transition. At this point, clear rcv_error and assert rcving.
  - SYNC: collect 8 bits. If the byte equals 8'h80, go to DATA with no byte_ready. Any other value sets rcv_error and goes to ERROR.
  - DATA: shift decoded, unstuffed bits right into the shift register (new bit enters bit 7). After 8 bits, copy the register to rcv_byte and pulse byte_ready. Any SE0 sample goes to EOP_CHK.
  - EOP_CHK requires SE0, SE0, then J on consecutive samples. On success, pulse eop, drop rcving and go to IDLE. If the bit count is nonzero at entry, also set rcv_error.
  - EOP_CHK: a non-SE0 sample before the second SE0, or K after SE0, sets rcv_error and goes to ERROR.
  - ERROR: hold rcving high. Wait for SE0 followed by J, then return to IDLE without pulsing eop.
- Simultaneous events: a byte completing on the same sample that enters EOP_CHK is impossible, because an SE0 sample is not a data bit. Stuff-error takes priority over byte completion on the same sample.

## Timing
- Reset values:
  - rcv_byte = 8'h00; byte_ready = 0; rcving = 0; rcv_error = 0; eop = 0.
  - FSM = IDLE; previous level = J; sample counter, ones-counter and bit counter = 0.
- Latency:
  - byte_ready rises the cycle after the sample clock of the 8th (unstuffed) data bit.
  - eop rises the cycle after the J sample.
  - rcving rises the cycle after the first K is seen.
- Resync: an edge arriving at any counter value restarts the counter, which tolerates ±3.5% clock drift.
- Reset mid-packet returns all state to reset values on the next clock edge. The bus is then treated as idle until the next J→K transition.

## Configuration
- RX_INPUT_SYNC_EN:
  - Defined: d_plus and d_minus each pass through a 2-flop synchronizer (reset value: J) before any logic, adding 2 cycles to every latency above.
  - Undefined: the inputs are used directly, and the pins must already be synchronous to clk.

## Structure
- Package usb_rx_pkg holds:
  - the FSM state enum
  - the line-state enum (J, K, SE0)
  - localparams SYNC_BYTE = 8'h80 and STUFF_LIMIT = 6
- One sub-module, rx_bit_sampler, handles input sync, the edge-resettable counter, the sample strobe and NRZI decoding. It outputs a sample strobe, the decoded bit and an se0 flag.
- byte_receiver holds the unstuffing logic, FSM, shift register and flags.

## Test plan
- SYNC, then 8'hA5, then EOP at 8 clk/bit: one byte_ready with rcv_byte = 8'hA5, then eop; rcv_error = 0.
- SYNC, then 8'hFF, 8'h00: a stuffed 0 after the sixth 1 is dropped; rcv_byte = 8'hFF then 8'h00.
- SYNC, then seven consecutive 1s with no stuff bit: rcv_error = 1, no byte_ready, state = ERROR until SE0/J, no eop pulse.
- SYNC value 8'h81: rcv_error = 1 and no byte_ready; the next clean packet clears rcv_error.
- SYNC, 8'h3C, then 4 bits, then EOP: one byte_ready (8'h3C), eop pulses and rcv_error = 1 (partial byte).
- 8'hC3 sent at 7.72 and 8.28 clk/bit (±3.5%): rcv_byte = 8'hC3. Assert n_rst mid-byte: next clock, all outputs are 0.
